// File: rtl/dualportram_pkg.sv
// dualportram_pkg: shared state and requester types for the dual-port RAM arbiter
package dualportram_pkg;
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} ramctl_state_t;
  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;
endpackage

// File: rtl/dualportram_arbiter_if.sv
// dualportram_arbiter_if: one requester's access channel into the RAM arbiter
interface dualportram_arbiter_if #(parameter int ADDRBITS = 9, parameter int DATAWIDTH = 8) ();
  logic req;
  logic we;
  logic [ADDRBITS-1:0] addr;
  logic [DATAWIDTH-1:0] wdata;
  logic gnt;
  logic rvalid;
  logic [DATAWIDTH-1:0] rdata;
  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dualportram_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter with a registered last-winner pointer
module rr_arbiter2
  import dualportram_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] cand,
  output logic [1:0] grant
);
  req_id_t last;
  // on a tie the requester that did not win last time goes first
  always_comb grant = !enable ? 2'b00 : (&cand) ? (last == REQ_B ? 2'b01 : 2'b10) : cand;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last <= REQ_B;
    else if (|grant) last <= grant[1] ? REQ_B : REQ_A;
endmodule

// File: rtl/dualportram_arbiter.sv
// dualportram_arbiter: shares one dual-port RAM between two requesters, with a clear sequencer
module dualportram_arbiter
  import dualportram_pkg::*;
#(
  parameter int ADDRBITS       = 9,
  parameter int DATAWIDTH      = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  output logic                 ready,
  dualportram_arbiter_if.slave a,
  dualportram_arbiter_if.slave b,
  output logic [ADDRBITS-1:0]  ram_waddr,
  output logic [DATAWIDTH-1:0] ram_din,
  output logic                 ram_write_en,
  output logic [ADDRBITS-1:0]  ram_raddr,
  input  logic [DATAWIDTH-1:0] ram_dout
);
  ramctl_state_t state, state_n;
  logic [ADDRBITS-1:0] cnt, raddr_q;
  logic [1:0] wg, rg;
  logic en, rv;
  req_id_t rtag;
  assign ready = state == RUN;
  assign en = ready && reset_n;
  always_comb state_n = state == CLEAR ? ((&cnt) ? RUN : CLEAR) : (clear ? CLEAR : RUN);
  rr_arbiter2 u_warb (.clk, .reset_n, .enable(en), .cand({b.req & b.we, a.req & a.we}), .grant(wg));
  rr_arbiter2 u_rarb (.clk, .reset_n, .enable(en), .cand({b.req & ~b.we, a.req & ~a.we}), .grant(rg));
  // cnt is zero outside CLEAR, so an idle write port parks at address 0
  always_comb begin
    ram_write_en = (state == CLEAR && reset_n) || (|wg);
    ram_waddr = wg[1] ? b.addr : wg[0] ? a.addr : cnt;
    ram_din = wg[1] ? b.wdata : wg[0] ? a.wdata : '0;
    ram_raddr = rg[1] ? b.addr : rg[0] ? a.addr : raddr_q;
  end
  assign a.gnt = wg[0] | rg[0];
  assign b.gnt = wg[1] | rg[1];
  assign a.rvalid = rv && rtag == REQ_A;
  assign b.rvalid = rv && rtag == REQ_B;
  assign a.rdata = ram_dout;
  assign b.rdata = ram_dout;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= CLEAR_ON_RESET ? CLEAR : RUN;
      cnt <= '0;
      raddr_q <= '0;
      rv <= 1'b0;
      rtag <= REQ_A;
    end else begin
      state <= state_n;
      cnt <= state == CLEAR ? cnt + 1'b1 : '0;
      raddr_q <= ram_raddr;
      rv <= |rg;
      rtag <= rg[1] ? REQ_B : REQ_A;
    end
endmodule

// File: tb/tb_dualportram_arbiter.sv
// tb_dualportram_arbiter: random and directed stimulus checked against a behavioural model of the arbiter
module tb_dualportram_arbiter;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int N = 1 << AW;
  localparam bit CLR = 1'b1;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic clear = 1'b0;
  logic ready, ram_write_en;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_din, ram_dout;
  dualportram_arbiter_if #(.ADDRBITS(AW), .DATAWIDTH(DW)) a_if ();
  dualportram_arbiter_if #(.ADDRBITS(AW), .DATAWIDTH(DW)) b_if ();
  dualportram_arbiter #(.ADDRBITS(AW), .DATAWIDTH(DW), .CLEAR_ON_RESET(CLR)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .ready(ready), .a(a_if), .b(b_if),
    .ram_waddr(ram_waddr), .ram_din(ram_din), .ram_write_en(ram_write_en),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout)
  );
  always #5 clk = ~clk;
  // the RAM itself: registered read, write-through on a same-address collision
  logic [DW-1:0] ram [N];
  always @(posedge clk) begin
    if (ram_write_en) ram[ram_waddr] <= ram_din;
    ram_dout <= (ram_write_en && ram_waddr == ram_raddr) ? ram_din : ram[ram_raddr];
  end
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  bit m_run = 1'b0;
  int m_cnt = 0, m_wlast = 1, m_rlast = 1, m_pend = -1, m_raddr = 0;
  logic [DW-1:0] m_pdata;
  logic [DW-1:0] mem_m [N];
  bit a_took, b_took;
  always @(negedge clk) begin
    int ww, rw, wa, ra;
    logic [DW-1:0] wd;
    bit aw, bw, ar, br;
    a_took = a_if.gnt;
    b_took = b_if.gnt;
    if (!reset_n) begin
      chk("rst_ready", ready, CLR ? 0 : 1);
      chk("rst_gnt", {a_if.gnt, b_if.gnt}, 0);
      chk("rst_rvalid", {a_if.rvalid, b_if.rvalid}, 0);
      chk("rst_we", ram_write_en, 0);
      chk("rst_waddr", ram_waddr, 0);
      chk("rst_raddr", ram_raddr, 0);
      m_run = !CLR; m_cnt = 0; m_wlast = 1; m_rlast = 1; m_pend = -1; m_raddr = 0;
    end else begin
      chk("a_rvalid", a_if.rvalid, m_pend == 0);
      chk("b_rvalid", b_if.rvalid, m_pend == 1);
      if (m_pend == 0) chk("a_rdata", a_if.rdata, m_pdata);
      if (m_pend == 1) chk("b_rdata", b_if.rdata, m_pdata);
      if (!m_run) begin
        chk("clr_ready", ready, 0);
        chk("clr_gnt", {a_if.gnt, b_if.gnt}, 0);
        chk("clr_we", ram_write_en, 1);
        chk("clr_waddr", ram_waddr, m_cnt);
        chk("clr_din", ram_din, 0);
        mem_m[m_cnt] = '0;
        m_pend = -1;
        m_cnt++;
        if (m_cnt == N) begin m_run = 1'b1; m_cnt = 0; end
      end else begin
        aw = a_if.req && a_if.we; bw = b_if.req && b_if.we;
        ar = a_if.req && !a_if.we; br = b_if.req && !b_if.we;
        ww = (aw && bw) ? 1 - m_wlast : aw ? 0 : bw ? 1 : -1;
        rw = (ar && br) ? 1 - m_rlast : ar ? 0 : br ? 1 : -1;
        wa = ww == 1 ? int'(b_if.addr) : ww == 0 ? int'(a_if.addr) : 0;
        wd = ww == 1 ? b_if.wdata : ww == 0 ? a_if.wdata : '0;
        ra = rw == 1 ? int'(b_if.addr) : rw == 0 ? int'(a_if.addr) : m_raddr;
        chk("run_ready", ready, 1);
        chk("a_gnt", a_if.gnt, ww == 0 || rw == 0);
        chk("b_gnt", b_if.gnt, ww == 1 || rw == 1);
        chk("run_we", ram_write_en, ww >= 0);
        chk("run_waddr", ram_waddr, wa);
        chk("run_din", ram_din, wd);
        chk("run_raddr", ram_raddr, ra);
        if (rw >= 0) begin
          m_pdata = (ww >= 0 && wa == ra) ? wd : mem_m[ra];
          m_rlast = rw;
        end
        m_pend = rw;
        m_raddr = ra;
        if (ww >= 0) begin mem_m[wa] = wd; m_wlast = ww; end
        if (clear) begin m_run = 1'b0; m_cnt = 0; end
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_a(input bit req, input bit we, input int addr, input int data);
    a_if.req = req; a_if.we = we; a_if.addr = AW'(addr); a_if.wdata = DW'(data);
  endtask
  task automatic set_b(input bit req, input bit we, input int addr, input int data);
    b_if.req = req; b_if.we = we; b_if.addr = AW'(addr); b_if.wdata = DW'(data);
  endtask
  function automatic int rnd_addr();
    return $urandom_range(0, 15) + ($urandom_range(0, 1) ? N - 16 : 0);
  endfunction
  // a requester keeps its request until it is granted
  task automatic rnd(input bit allow_clear);
    if (!a_if.req || a_took) set_a($urandom_range(0, 1), $urandom_range(0, 1), rnd_addr(), $urandom_range(0, 255));
    if (!b_if.req || b_took) set_b($urandom_range(0, 1), $urandom_range(0, 1), rnd_addr(), $urandom_range(0, 255));
    clear = allow_clear && $urandom_range(0, 399) == 0;
  endtask
  // call at a negedge; counts negedges with ready low
  task automatic wait_ready(input bit rand_on, output int n);
    n = 0;
    while (!ready && n < 2000) begin
      n++;
      cyc();
      if (rand_on) rnd(1'b0);
      @(negedge clk);
    end
  endtask
  initial begin
    int n;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    #1 reset_n = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b1;
    @(negedge clk);
    wait_ready(1'b0, n);
    chk("clear_len_init", n, 512);
    cyc(); set_a(1, 1, 1, 'h11); set_b(1, 1, 2, 'h22);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alt_a", a_if.gnt, i % 2 == 0);
      chk("alt_b", b_if.gnt, i % 2 == 1);
      if (i < 3) cyc();
    end
    cyc(); set_a(1, 0, 'h123, 0); set_b(0, 0, 0, 0);
    @(negedge clk); chk("rd_gnt", a_if.gnt, 1);
    cyc(); set_a(1, 0, 1, 0);
    @(negedge clk); chk("rd_cleared", a_if.rdata, 0); chk("rd_cleared_v", a_if.rvalid, 1);
    cyc(); set_a(1, 0, 2, 0);
    @(negedge clk); chk("rd_addr1", a_if.rdata, 'h11);
    cyc(); set_a(1, 1, 'h10, 'h5A);
    @(negedge clk); chk("rd_addr2", a_if.rdata, 'h22); chk("wr5a_gnt", a_if.gnt, 1);
    cyc(); set_a(1, 0, 'h10, 0);
    @(negedge clk); chk("rd10_gnt", a_if.gnt, 1); chk("wr_no_rvalid", a_if.rvalid, 0);
    cyc(); set_a(1, 1, 'h20, 'h77); set_b(1, 0, 'h20, 0);
    @(negedge clk);
    chk("rd10_data", a_if.rdata, 'h5A); chk("rd10_bv", b_if.rvalid, 0);
    chk("split_a", a_if.gnt, 1); chk("split_b", b_if.gnt, 1);
    cyc(); set_a(0, 0, 0, 0); set_b(1, 0, 'h30, 0); clear = 1'b1;
    @(negedge clk); chk("wt_valid", b_if.rvalid, 1); chk("wt_data", b_if.rdata, 'h77); chk("clr_bgnt", b_if.gnt, 1);
    cyc(); clear = 1'b0; set_b(0, 0, 0, 0); set_a(1, 1, 5, 9);
    @(negedge clk);
    chk("clr_rvalid", b_if.rvalid, 1); chk("clr_rdata", b_if.rdata, 0);
    chk("clr_ready_drop", ready, 0); chk("clr_ign", a_if.gnt, 0);
    wait_ready(1'b1, n);
    chk("clear_len_pulse", n, 512);
    for (int i = 0; i < 3000; i++) begin
      cyc(); rnd(1'b1);
      @(negedge clk);
    end
    cyc(); clear = 1'b0;
    @(negedge clk);
    wait_ready(1'b1, n);
    cyc(); set_a(0, 0, 0, 0); set_b(0, 0, 0, 0); clear = 1'b1;
    @(negedge clk);
    cyc(); clear = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 600 && ram_waddr != 100; i++) begin
      cyc();
      @(negedge clk);
    end
    chk("reach_100", ram_waddr, 100);
    cyc(); reset_n = 1'b0;
    @(negedge clk); chk("mid_rst_we", ram_write_en, 0);
    cyc();
    cyc(); reset_n = 1'b1;
    @(negedge clk); chk("restart_addr", ram_waddr, 0);
    wait_ready(1'b0, n);
    chk("clear_len_rst", n, 512);
    cyc(); set_a(1, 0, 'h20, 0);
    @(negedge clk);
    cyc(); set_a(0, 0, 0, 0);
    @(negedge clk); chk("post_rst_rd", a_if.rdata, 0); chk("post_rst_rv", a_if.rvalid, 1);
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
